// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_checker.sv
// Protocol and occupancy properties of the fetch stage.
module fetch_unit_checker (
  input logic       clk_i,
  input logic       rst_ni,
  input logic       push_i,
  input logic       full_i,
  input logic       rvalid_i,
  input logic       inflight_i,
  input logic [1:0] addr_lsb_i
);

  // The credit scheme must never let a response land in a full buffer.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_i));

  // Memory may only respond to a request it granted in the previous cycle.
  a_rvalid_granted: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_i && !inflight_i));

  // Fetch addresses are always word aligned.
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    addr_lsb_i == 2'b00);

endmodule

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of {pc, instr} entries. The head entry is read
// straight from register storage, so the outputs carry no combinational
// path from push/pop/flush.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            do_push_s;
  logic            do_pop_s;

  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify push/pop against occupancy and compute the next entry count.
  always_comb begin
    do_push_s = push_i & (~full_o | pop_i);
    do_pop_s  = pop_i & ~empty_o;
    count_d   = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; flush empties the queue but leaves storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests over a
// req/gnt interface with a fixed one-cycle response, buffers returned words
// and hands {pc, instr} to the decoder. A redirect flushes and restarts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          inflight_q, inflight_d;
  logic          discard_q, discard_d;

  logic [CW-1:0] count_s;
  logic [CW:0]   used_s;
  logic          credit_s;
  logic          req_s;
  logic          grant_s;
  logic          rsp_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;

  // Fetch runs only while enabled; in-flight responses are taken in any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_en_i) state_d = ACTIVE;
        else            state_d = IDLE;
      end
      ACTIVE: begin
        if (!fetch_en_i) state_d = IDLE;
        else             state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request credit, response handling and next fetch/tracking state.
  always_comb begin
    used_s   = {1'b0, count_s} + {{CW{1'b0}}, inflight_q};
    credit_s = (used_s < (CW+1)'(DEPTH));
    req_s    = (state_q == ACTIVE) & fetch_en_i & credit_s;
    grant_s  = req_s & imem_gnt_i;
    rsp_s    = imem_rvalid_i & inflight_q;
    // A response arriving with a redirect belongs to the old stream.
    push_s   = rsp_s & ~discard_q & ~redirect_valid_i;
    pop_s    = ~empty_s & out_ready_i;

    push_entry_s.pc    = resp_pc_q;
    push_entry_s.instr = imem_rdata_i;

    if (redirect_valid_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
    end else if (grant_s) begin
      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (grant_s) resp_pc_d = fetch_pc_q;
    else         resp_pc_d = resp_pc_q;

    inflight_d = grant_s;

    // A grant in the redirect cycle returns a stale word next cycle.
    if (redirect_valid_i) begin
      discard_d = grant_s;
    end else if (rsp_s) begin
      discard_d = 1'b0;
    end else begin
      discard_d = discard_q;
    end
  end

  // FSM, fetch PC and outstanding-request tracking registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= 32'h0000_0000;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid_i),
    .head_o      (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .count_o     (count_s)
  );

  fetch_unit_checker u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push_s),
    .full_i     (full_s),
    .rvalid_i   (imem_rvalid_i),
    .inflight_i (inflight_q),
    .addr_lsb_i (fetch_pc_q[1:0])
  );

  assign imem_req_o  = req_s;
  assign imem_addr_o = fetch_pc_q;
  assign out_valid_o = ~empty_s;
  assign out_pc_o    = head_s.pc;
  assign out_instr_o = head_s.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model of the
// fetch stream plus a one-cycle memory responder, with directed scenarios
// followed by randomized traffic.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, gnt, rvalid, redir, out_ready;
  logic [31:0] rdata, redir_pc;
  logic        req, out_valid;
  logic [31:0] addr, out_pc, out_instr;
  logic        rvalid2, req2, ov2;
  logic [31:0] rdata2, addr2, opc2, oin2;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_instr_o(out_instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .out_valid_o(ov2), .out_ready_i(1'b1),
    .out_pc_o(opc2), .out_instr_o(oin2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_rpc;
  bit          m_out, m_drop, m_active;
  logic [31:0] wrap_pcs[$];
  logic [31:0] wrap_instrs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = 32'h0000_0000;
    m_rpc    = 32'h0000_0000;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    m_active = 1'b0;
  endtask

  function automatic bit model_req();
    return m_active && fetch_en && ((q.size() + (m_out ? 1 : 0)) < DEPTH);
  endfunction

  // One clock cycle: check at the falling edge, apply the rising-edge
  // effects to the model, then drive memory responses just after the edge.
  task automatic tick();
    bit          exp_req;
    ent_t        e;
    logic        nxt_rv, nxt_rv2;
    logic [31:0] nxt_rd, nxt_rd2;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_req",   {31'd0, req},       32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_addr",  addr,               32'h0000_0000);
      check("rst_pc",    out_pc,             32'd0);
      check("rst_instr", out_instr,          32'd0);
    end else begin
      exp_req = model_req();
      check("req",       {31'd0, req},       {31'd0, exp_req});
      check("addr",      addr,               m_pc);
      check("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
      if (q.size() != 0) begin
        check("out_pc",    out_pc,    q[0].pc);
        check("out_instr", out_instr, q[0].instr);
      end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (m_out && !m_drop && !redir) begin
        e.pc    = m_rpc;
        e.instr = m_rpc ^ KEY;
        q.push_back(e);
      end
      m_out  = 1'b0;
      m_drop = 1'b0;
      if (redir) q.delete();
      if (exp_req && gnt) begin
        m_out  = 1'b1;
        m_rpc  = m_pc;
        m_drop = redir;
      end
      if (redir) m_pc = {redir_pc[31:2], 2'b00};
      else if (exp_req && gnt) m_pc = m_pc + 32'd4;
      m_active = fetch_en;
    end
    if (rst_n && ov2 && wrap_pcs.size() < 3) begin
      wrap_pcs.push_back(opc2);
      wrap_instrs.push_back(oin2);
    end
    nxt_rv  = rst_n & req & gnt;
    nxt_rd  = addr ^ KEY;
    nxt_rv2 = rst_n & req2;
    nxt_rd2 = addr2 ^ KEY;
    @(posedge clk);
    #1;
    rvalid  = nxt_rv;
    rdata   = nxt_rd;
    rvalid2 = nxt_rv2;
    rdata2  = nxt_rd2;
  endtask

  task automatic do_reset(input int cycles);
    rst_n   = 1'b0;
    rvalid  = 1'b0;
    rvalid2 = 1'b0;
    model_reset();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; fetch_en = 1'b1; gnt = 1'b1; out_ready = 1'b1;
    redir = 1'b0; redir_pc = 32'h0; rvalid = 1'b0; rdata = 32'h0;
    rvalid2 = 1'b0; rdata2 = 32'h0;
    model_reset();

    // Reset held with fetch enabled, then a free-running stream.
    do_reset(3);
    repeat (14) tick();

    // Wrap-around instance streams FFFFFFF8, FFFFFFFC, 00000000.
    check("wrap_count", 32'(wrap_pcs.size()), 32'd3);
    for (int i = 0; i < wrap_pcs.size(); i++) begin
      check("wrap_pc",    wrap_pcs[i],    32'hFFFF_FFF8 + 32'(4 * i));
      check("wrap_instr", wrap_instrs[i], (32'hFFFF_FFF8 + 32'(4 * i)) ^ KEY);
    end

    // Backpressure: decoder stalls, then resumes.
    out_ready = 1'b0;
    repeat (10) tick();
    out_ready = 1'b1;
    repeat (10) tick();

    // Redirect to 0x100 in the cycle that 0x8 is granted.
    do_reset(2);
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!done && m_pc == 32'h8 && model_req()) begin
        redir    = 1'b1;
        redir_pc = 32'h0000_0100;
        done     = 1'b1;
      end
      tick();
      redir = 1'b0;
    end

    // Misaligned redirect while memory withholds grant.
    gnt      = 1'b0;
    redir    = 1'b1;
    redir_pc = 32'h0000_0103;
    tick();
    redir = 1'b0;
    repeat (4) tick();
    gnt = 1'b1;
    repeat (10) tick();

    // Asynchronous reset mid-stream with the buffer full.
    out_ready = 1'b0;
    repeat (6) tick();
    #2;
    rst_n   = 1'b0;
    rvalid  = 1'b0;
    rvalid2 = 1'b0;
    #1;
    check("async_req",   {31'd0, req},       32'd0);
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_pc",    out_pc,             32'd0);
    model_reset();
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      gnt       = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      fetch_en  = ($urandom_range(0, 9) < 9);
      redir     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redir_pc = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F);
      else                           redir_pc = $urandom() & 32'h0000_0FFF;
      tick();
    end
    redir = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
